pmod_mic_capture: RTL
=====================

# pmod_mic_capture

- SPI master and deserializer for the PmodMIC ADC (ADCS7476-style, 16-clock frame: 4 leading zeros, then 12-bit sample MSB first).
- Sits directly downstream of the mic PMOD pins and upstream of the audio/LED logic.
- Generates SCK and CS, samples MISO at a fixed rate, and presents one parallel 12-bit sample per frame with a single-cycle valid strobe.

## Interface

Parameters:
- CLK_DIV, 4 — half-period of sclk in clk cycles (12.5 MHz sclk from 100 MHz clk); legal ≥ 2.
- SAMPLE_PERIOD, 2268 — clk cycles between conversion starts (~44.1 kHz); legal ≥ 34*CLK_DIV+2.

Ports:
- clk  in  1  100 MHz system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- sclk  out  1  SPI clock to PMOD, idles high.
- cs_n  out  1  SPI chip select, active low.
- miso  in  1  ADC serial data.
- sample  out  12  last captured sample, unsigned.
- sample_valid  out  1  one-cycle pulse when sample updates.
- frame_err  out  1  set with each sample_valid: any of the 4 leading bits was 1.
- overrun  out  1  sticky: a start tick arrived while a frame was in progress.
- busy  out  1  high from cs_n fall until cs_n rise.
- peak  out  11  peak magnitude, present only with MIC_PEAK_HOLD_EN.
- peak_clr  in  1  clears peak, present only with MIC_PEAK_HOLD_EN.

## Operation

- Reset values: sclk=1, cs_n=1, sample=0, sample_valid=0, frame_err=0, overrun=0, busy=0, peak=0, state=IDLE, all counters=0.
- Period counter runs free from reset, counting 0..SAMPLE_PERIOD-1 and wrapping. Start tick = count==SAMPLE_PERIOD-1.
- States:
  - IDLE: cs_n=1, sclk=1. On tick → LEAD; cs_n←0, busy←1.
  - LEAD: hold sclk=1 for CLK_DIV cycles → SHIFT.
  - SHIFT: toggle sclk every CLK_DIV cycles. On each clk edge that drives sclk 0→1, shift miso into a 16-bit shift register (MSB first) and increment the bit counter. After the 16th rising edge → DONE.
  - DONE (one cycle): cs_n←1, busy←0, sample←shift[11:0], frame_err←|shift[15:12], sample_valid←1 → IDLE.
- Tick while not IDLE: the tick is dropped, overrun←1 and stays set until rst. The frame in progress is unaffected.
- rst mid-frame: next cycle outputs equal their reset values. The partial frame is discarded with no sample_valid.
- sample and frame_err hold between frames.

## Timing

- T = cycle the tick is asserted. cs_n low from T+1.
- sclk falling edge k at T+1+(2k-1)*CLK_DIV; rising edge k at T+1+2k*CLK_DIV, for k=1..16.
- miso is captured on the same clk edge that raises sclk. The ADC updates on the falling edge, so data has CLK_DIV cycles of setup.
- cs_n rises, sample_valid pulses, and sample updates at T+2+32*CLK_DIV. Defaults: T+130.
- cs_n high time between frames = SAMPLE_PERIOD-32*CLK_DIV-1 cycles.
- All outputs are registered. No combinational path from miso to any output.

## Configuration

- MIC_PEAK_HOLD_EN defined: adds peak and peak_clr.
  - In the DONE cycle, mag = |sample_new - 2048| (11 bits, 2048 saturates to 2047 is not needed: max 2048 → clamp to 2047).
  - peak←max(peak, mag).
  - peak_clr takes priority over an update in the same cycle: peak←0.
  - peak updates the cycle after sample_valid.
- Undefined: neither port exists and no peak logic is synthesized. All other behaviour is identical.

## Test plan

- Reset then idle: rst held 5 cycles → sclk=1, cs_n=1, sample=0, no sample_valid until the first tick at cycle 2267.
- Nominal frame: model drives miso bits 0000_1010_0101_1100 on sclk falling edges → sample=0xA5C, frame_err=0, sample_valid exactly one cycle at T+130, exactly 16 sclk rising edges while cs_n=0.
- Leading-bit error: model drives 0100_1111_1111_1111 → sample=0xFFF, frame_err=1. The next clean frame clears frame_err.
- Overrun: SAMPLE_PERIOD=100, CLK_DIV=4 (illegal) → overrun=1 after the second tick, frames still complete with 16 edges, overrun stays 1.
- Reset mid-frame: assert rst after the 7th rising edge → next cycle cs_n=1, sclk=1, no sample_valid, sample still holds its previous value of 0.
- MIC_PEAK_HOLD_EN: samples 0x900, 0x700, 0x000 → peak 256, 256, 2047. peak_clr coinciding with the third sample_valid+1 → peak=0.

Source files
------------

// File: rtl/pmod_mic_capture.sv
// SPI master and 16-clock deserializer for the PmodMIC ADC (4 leading zeros, 12-bit sample MSB first).
// Optional peak-magnitude hold is enabled by defining MIC_PEAK_HOLD_EN.
module pmod_mic_capture #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2268
) (
  input  logic        clk,
  input  logic        rst,
  output logic        sclk,
  output logic        cs_n,
  input  logic        miso,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy,
`ifdef MIC_PEAK_HOLD_EN
  output logic [10:0] peak,
  input  logic        peak_clr,
`endif
  output logic [1:0]  state_dbg
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;
  logic [11:0]   sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic tick, div_end, rise;

  assign tick    = (per_q == PER_LAST);
  assign div_end = (div_q == DIV_LAST);
  // A rising sclk edge is the clk edge that ends a low half-period.
  assign rise    = (state_q == SHIFT) && div_end && !sclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      per_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      sclk_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = LEAD;
      LEAD:    if (div_end) state_d = SHIFT;
      SHIFT:   if (rise && bit_q == 4'd15) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    per_d    = tick ? '0 : per_q + PW'(1);
    ovr_d    = ovr_q | (tick && state_q != IDLE);
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    sample_d = sample_q;
    ferr_d   = ferr_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (tick) begin
          cs_n_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      LEAD: begin
        div_d = div_end ? '0 : div_q + DW'(1);
        if (div_end) sclk_d = 1'b0;
      end
      SHIFT: begin
        div_d = div_end ? '0 : div_q + DW'(1);
        if (div_end) sclk_d = ~sclk_q;
        if (rise) begin
          shift_d = {shift_q[14:0], miso};
          bit_d   = bit_q + 4'd1;
        end
      end
      default: begin
        div_d    = '0;
        bit_d    = '0;
        cs_n_d   = 1'b1;
        busy_d   = 1'b0;
        sample_d = shift_q[11:0];
        ferr_d   = |shift_q[15:12];
        valid_d  = 1'b1;
      end
    endcase
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign busy         = busy_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;
  assign state_dbg    = state_q;

`ifdef MIC_PEAK_HOLD_EN
  logic [10:0] peak_q, peak_d, mag;
  logic [11:0] below;

  // Distance from mid-scale; 2048 below mid-scale clamps to 2047.
  always_comb begin
    below = 12'd2048 - sample_q;
    if (sample_q[11])   mag = sample_q[10:0];
    else if (below[11]) mag = 11'h7ff;
    else                mag = below[10:0];
    peak_d = peak_q;
    if (peak_clr)                      peak_d = '0;
    else if (valid_q && mag > peak_q)  peak_d = mag;
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule
